// File: rtl/surface_pkg.sv
// Shared types and constants for the surface scheduler: FSM states, LFSR
// seed/taps, the fixed gap/transition lengths and the LFSR step function.
package surface_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } schedState_t;

    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    // Feedback bits 7,5,4,3 realise x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [3:0] FIXED_GAP  = 4'd8;
    localparam logic [3:0] FIXED_DIFF = 4'd3;
    localparam logic [2:0] MAX_LEVEL  = 3'd7;

    function automatic logic [7:0] lfsrStep(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/surface_scheduler_if.sv
// Control/status bundle between the game controller (master) and the
// surface scheduler (slave).
interface surface_scheduler_if;
    logic        Start;
    logic        Pause;
    logic        Collision;
    logic        MoveTick;
    logic        TransitionTick;
    logic [3:0]  TransitionDiff;
    logic [15:0] Score;
    logic [2:0]  Level;
    logic        Running;
    logic        GameOver;

    modport master (
        output Start, Pause, Collision,
        input  MoveTick, TransitionTick, TransitionDiff, Score, Level, Running, GameOver
    );

    modport slave (
        input  Start, Pause, Collision,
        output MoveTick, TransitionTick, TransitionDiff, Score, Level, Running, GameOver
    );
endinterface

// File: rtl/tick_divider.sv
// Programmable clock divider: emits a one-cycle Tick every Period enabled
// cycles; the count freezes while Enable is low and Clear restarts it.
module tick_divider (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [23:0] Period,
    input  logic        Enable,
    input  logic        Clear,
    output logic        Tick
);

    logic [23:0] count;

    // NOTE: Tick is decoded from the registered count so it lands in the same
    // cycle the count reaches Period-1 and never fires while disabled.
    assign Tick = Enable && (count >= Period - 24'd1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (Clear) begin
            count <= '0;
        end else if (Enable) begin
            count <= Tick ? '0 : count + 24'd1;
        end
    end

endmodule

// File: rtl/surface_scheduler.sv
// Game-pace scheduler: FSM, level-dependent move tick, score/level and surface
// transition timing. Define SURFACE_SCHED_LFSR_EN for LFSR-randomised gaps/lengths.
module surface_scheduler #(
    parameter logic [23:0] BASE_PERIOD     = 24'd5_000_000,
    parameter logic [23:0] PERIOD_STEP     = 24'd500_000,
    parameter logic [23:0] MIN_PERIOD      = 24'd1_500_000,
    parameter int          MOVES_PER_LEVEL = 32
) (
    input logic                Clk,
    input logic                Rst,
    surface_scheduler_if.slave Bus
);
    import surface_pkg::*;

    localparam int MC_W = (MOVES_PER_LEVEL > 1) ? $clog2(MOVES_PER_LEVEL) : 1;

    schedState_t     state, nextState;
    logic            clearGame, isRun, moveTick, transTick;
    logic [27:0]     reduction;
    logic [23:0]     period;
    logic [15:0]     score;
    logic [2:0]      level;
    logic [MC_W-1:0] moveCount;
    logic [3:0]      gapCount, gapTarget, transCount, diffOut, diffCand;
    logic [3:0]      newGap, newDiff;
    logic            transPending, transActive;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= nextState;
    end

    // NOTE: every output of this block is defaulted first so no path can hold
    // a previous value and infer a latch.
    always_comb begin
        nextState = state;
        clearGame = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (Bus.Start && !Bus.Collision) begin
                    nextState = RUN;
                    clearGame = 1'b1;
                end
            end
            RUN: begin
                if (Bus.Collision)  nextState = OVER;
                else if (Bus.Pause) nextState = PAUSE;
            end
            PAUSE: begin
                if (Bus.Collision)  nextState = OVER;
                else if (Bus.Pause) nextState = RUN;
            end
            default: nextState = IDLE;
        endcase
    end

    assign isRun     = (state == RUN);
    assign transTick = transPending && isRun;

    // Wide compare keeps the subtraction from wrapping when the step overshoots.
    always_comb begin
        reduction = 28'(level) * 28'(PERIOD_STEP);
        if (28'(BASE_PERIOD) > reduction + 28'(MIN_PERIOD)) period = BASE_PERIOD - reduction[23:0];
        else                                                period = MIN_PERIOD;
    end

    tick_divider uDivider (
        .Clk    (Clk),
        .Rst    (Rst),
        .Period (period),
        .Enable (isRun),
        .Clear  (clearGame),
        .Tick   (moveTick)
    );

`ifdef SURFACE_SCHED_LFSR_EN
    logic [7:0] lfsr;
    logic [2:0] diffLevel, diffPick;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsrStep(lfsr);
    end

    // A new game samples as if Level were already cleared.
    assign diffLevel = clearGame ? 3'd0 : level;
    assign diffPick  = (lfsr[6:4] < diffLevel) ? lfsr[6:4] : diffLevel;
    assign newGap    = 4'd4 + {1'b0, lfsr[2:0]};
    assign newDiff   = 4'd2 + {1'b0, diffPick};
`else
    assign newGap  = FIXED_GAP;
    assign newDiff = FIXED_DIFF;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            score        <= '0;
            level        <= '0;
            moveCount    <= '0;
            gapCount     <= '0;
            gapTarget    <= '0;
            transCount   <= '0;
            transActive  <= 1'b0;
            transPending <= 1'b0;
            diffOut      <= '0;
            diffCand     <= '0;
        end else if (clearGame) begin
            score        <= '0;
            level        <= '0;
            moveCount    <= '0;
            gapCount     <= '0;
            gapTarget    <= newGap;
            transCount   <= '0;
            transActive  <= 1'b0;
            transPending <= 1'b0;
            diffOut      <= '0;
            diffCand     <= newDiff;
        end else begin
            if (moveTick) begin
                if (score != 16'hFFFF) score <= score + 16'd1;
                if (moveCount == MC_W'(MOVES_PER_LEVEL - 1)) begin
                    moveCount <= '0;
                    if (level != MAX_LEVEL) level <= level + 3'd1;
                end else begin
                    moveCount <= moveCount + MC_W'(1);
                end
            end

            // Gap counting pauses from the triggering move until the transition ends.
            if (transTick) begin
                transPending <= 1'b0;
                transActive  <= 1'b1;
                transCount   <= '0;
                diffOut      <= diffCand;
            end else if (moveTick && transActive) begin
                if (transCount == diffOut + 4'd1) begin
                    transActive <= 1'b0;
                    transCount  <= '0;
                    gapCount    <= '0;
                    gapTarget   <= newGap;
                    diffCand    <= newDiff;
                end else begin
                    transCount <= transCount + 4'd1;
                end
            end else if (moveTick && !transPending) begin
                gapCount <= gapCount + 4'd1;
                if (gapCount + 4'd1 == gapTarget) transPending <= 1'b1;
            end
        end
    end

    assign Bus.MoveTick       = moveTick;
    assign Bus.TransitionTick = transTick;
    assign Bus.TransitionDiff = diffOut;
    assign Bus.Score          = score;
    assign Bus.Level          = level;
    assign Bus.Running        = isRun;
    assign Bus.GameOver       = (state == OVER);

endmodule

// File: tb/tb_surface_scheduler.sv
// Self-checking bench for surface_scheduler (default build, fixed gap 8 / diff 3):
// directed scenarios plus random Start/Pause/Collision against a move-count model.
module tb_surface_scheduler;

    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINP = 6;
    localparam int MPL  = 4;
    localparam int GAP  = 8;
    localparam int DIFF = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic Clk = 1'b0;
    logic Rst;

    int total = 0;
    int bad   = 0;
    int cycleNo = 0;

    int mState, mElapsed, mMoves, mDiff;
    bit mPending;
    int moveLog[$];
    int transLog[$];
    int startCycle, resumeCycle, scoreBefore, n0, t0, m0;

    always #5 Clk = ~Clk;

    surface_scheduler_if bus();

    surface_scheduler #(
        .BASE_PERIOD     (24'd10),
        .PERIOD_STEP     (24'd2),
        .MIN_PERIOD      (24'd6),
        .MOVES_PER_LEVEL (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    // Reference model: everything derives from the number of moves in this game.
    function automatic int mLevel();
        int l = mMoves / MPL;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic int mPeriod();
        int p = BASE - mLevel() * STEP;
        return (p > MINP) ? p : MINP;
    endfunction

    function automatic int mScore();
        return (mMoves > 65535) ? 65535 : mMoves;
    endfunction

    // Transitions trigger at move GAP, then every GAP + (DIFF+2) moves.
    function automatic bit mTriggers(input int n);
        return (n >= GAP) && ((n - GAP) % (GAP + DIFF + 2) == 0);
    endfunction

    task automatic modelReset();
        mState   = M_IDLE;
        mElapsed = 0;
        mMoves   = 0;
        mDiff    = 0;
        mPending = 1'b0;
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge,
    // then advance the model across the rising edge.
    task automatic step(input bit s, input bit p, input bit c);
        bit expMove, expTrans;
        bus.Start     = s;
        bus.Pause     = p;
        bus.Collision = c;
        @(negedge Clk);
        expMove  = (mState == M_RUN) && (mElapsed == mPeriod() - 1);
        expTrans = (mState == M_RUN) && mPending;
        check("MoveTick",       bus.MoveTick,       expMove);
        check("TransitionTick", bus.TransitionTick, expTrans);
        check("TransitionDiff", bus.TransitionDiff, mDiff);
        check("Score",          bus.Score,          mScore());
        check("Level",          bus.Level,          mLevel());
        check("Running",        bus.Running,        mState == M_RUN);
        check("GameOver",       bus.GameOver,       mState == M_OVER);
        if (bus.MoveTick === 1'b1)       moveLog.push_back(cycleNo);
        if (bus.TransitionTick === 1'b1) transLog.push_back(cycleNo);
        @(posedge Clk);
        if (expMove) begin
            mMoves++;
            mElapsed = 0;
            if (mTriggers(mMoves)) mPending = 1'b1;
        end else if (mState == M_RUN) begin
            mElapsed++;
        end
        if (expTrans) begin
            mPending = 1'b0;
            mDiff    = DIFF;
        end
        case (mState)
            M_IDLE, M_OVER: if (s && !c) begin
                mState   = M_RUN;
                mMoves   = 0;
                mElapsed = 0;
                mPending = 1'b0;
                mDiff    = 0;
            end
            M_RUN:   if (c) mState = M_OVER; else if (p) mState = M_PAUSE;
            M_PAUSE: if (c) mState = M_OVER; else if (p) mState = M_RUN;
            default: mState = M_IDLE;
        endcase
        cycleNo++;
        #1;
        bus.Start     = 1'b0;
        bus.Pause     = 1'b0;
        bus.Collision = 1'b0;
    endtask

    task automatic runUntilMove(input string tag, input int budget);
        int n = moveLog.size();
        int spent = 0;
        while (moveLog.size() == n && spent < budget) begin
            step(1'b0, 1'b0, 1'b0);
            spent++;
        end
        check(tag, moveLog.size() > n, 1);
    endtask

    task automatic runUntilTrans(input string tag, input int budget);
        int n = transLog.size();
        int spent = 0;
        while (transLog.size() == n && spent < budget) begin
            step(1'b0, 1'b0, 1'b0);
            spent++;
        end
        check(tag, transLog.size() > n, 1);
    endtask

    initial begin
        bit rs, rp, rc;
        Rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.Pause     = 1'b0;
        bus.Collision = 1'b0;
        modelReset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_Running",        bus.Running,        0);
        check("rst_GameOver",       bus.GameOver,       0);
        check("rst_Score",          bus.Score,          0);
        check("rst_Level",          bus.Level,          0);
        check("rst_TransitionDiff", bus.TransitionDiff, 0);
        check("rst_MoveTick",       bus.MoveTick,       0);
        check("rst_TransitionTick", bus.TransitionTick, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Pause and Collision have no effect while idle.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Long run: first move latency, per-level periods, Level saturation, transitions.
        moveLog.delete();
        transLog.delete();
        startCycle = cycleNo;
        step(1'b1, 1'b0, 1'b0);
        repeat (320) step(1'b0, 1'b0, 1'b0);
        check("enough_moves",       moveLog.size() >= 34, 1);
        check("first_move_latency", moveLog[0] - startCycle, 10);
        check("period_level0",      moveLog[1] - moveLog[0], 10);
        check("period_level1",      moveLog[4] - moveLog[3], 8);
        check("period_level2",      moveLog[8] - moveLog[7], 6);
        check("period_level3",      moveLog[12] - moveLog[11], 6);
        check("level_saturated",    bus.Level, 7);
        check("enough_transitions", transLog.size() >= 3, 1);
        check("trans1_after_move8",  transLog[0] - moveLog[7], 1);
        check("trans2_after_move21", transLog[1] - moveLog[20], 1);
        check("trans3_after_move34", transLog[2] - moveLog[33], 1);

        // Pause three cycles into a period; the divider must resume where it stopped.
        runUntilMove("pre_pause_move", 20);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        scoreBefore = mScore();
        m0 = moveLog.size();
        repeat (15) step(1'b0, 1'b0, 1'b0);
        check("pause_no_moves",     moveLog.size() - m0, 0);
        check("pause_score_frozen", bus.Score, scoreBefore);
        resumeCycle = cycleNo;
        step(1'b0, 1'b1, 1'b0);
        n0 = moveLog.size();
        runUntilMove("resume_move", 20);
        // Three of the six cycles of the level-7 period elapsed before the pause.
        check("resume_divider_kept", moveLog[n0] - resumeCycle, MINP - 3);

        // Collision wins over a simultaneous Start; a later Start begins a fresh game.
        step(1'b1, 1'b0, 1'b1);
        check("collision_gameover", bus.GameOver, 1);
        check("collision_running",  bus.Running,  0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("restart_running", bus.Running, 1);
        check("restart_score",   bus.Score,   0);
        check("restart_level",   bus.Level,   0);

        // Asynchronous reset in the middle of an active transition.
        runUntilTrans("reach_transition", 200);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("mid_transition_diff", bus.TransitionDiff, DIFF);
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst_Running",        bus.Running,        0);
        check("async_rst_GameOver",       bus.GameOver,       0);
        check("async_rst_Score",          bus.Score,          0);
        check("async_rst_Level",          bus.Level,          0);
        check("async_rst_TransitionDiff", bus.TransitionDiff, 0);
        check("async_rst_MoveTick",       bus.MoveTick,       0);
        check("async_rst_TransitionTick", bus.TransitionTick, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        modelReset();
        n0 = moveLog.size();
        t0 = transLog.size();
        repeat (30) step(1'b0, 1'b0, 1'b0);
        check("post_rst_no_moves",       moveLog.size() - n0, 0);
        check("post_rst_no_transitions", transLog.size() - t0, 0);

        // Random control pulses, including same-cycle combinations.
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 99) < 3);
            rp = ($urandom_range(0, 99) < 2);
            rc = ($urandom_range(0, 999) < 3);
            step(rs, rp, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
